// File: rtl/gray_updown_counter_pkg.sv
// Shared helpers for the Gray up/down counter: prescaler sizing and Gray/binary conversion.
// Conversions work on 64-bit zero-extended values; callers truncate to their width.
package gray_updown_counter_pkg;

  localparam int MAX_W = 64;

  // Ceil(log2(v)) with a floor of 1, so a divide-by-1 prescaler still has a legal width.
  function automatic int clog2(input longint unsigned v);
    longint unsigned x;
    int r;
    x = 1;
    r = 0;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_counter_tick_prescaler.sv
// Prescaler: raises step combinationally on the enabled cycle where the count is DIVISOR-1.
// clr zeroes the count regardless of en; en=0 freezes the count.
module tick_prescaler #(
  parameter int unsigned DIVISOR = 100000000,
  parameter int          PW      = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [PW-1:0] LAST = PW'(DIVISOR - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign step = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gray_updown_counter.sv
// N-bit up/down counter advanced every DIVISOR enabled cycles, with registered Gray and binary views.
// Count, tick and wrap all update on the step edge; load wins over a coincident step and drops it.
module gray_updown_counter
  import gray_updown_counter_pkg::*;
#(
  parameter int          N       = 4,
  parameter int unsigned DIVISOR = 100000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tick,
  output logic         wrap
);

  localparam int PW = clog2(DIVISOR);

  logic         step;
  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic         tick_q, tick_d;
  logic         wrap_q, wrap_d;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  tick_prescaler #(
    .DIVISOR (DIVISOR),
    .PW      (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  always_comb begin
    bin_d  = bin_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (step) begin
      bin_d  = up_dn ? bin_q + N'(1) : bin_q - N'(1);
      tick_d = 1'b1;
      wrap_d = up_dn ? (&bin_q) : ~(|bin_q);
    end
    // Gray is derived from the next binary value so both registers agree every cycle.
    gray_d = to_gray(bin_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench: DUT a is N=4/DIVISOR=4, DUT b is N=4/DIVISOR=1; both share all inputs.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] gray_a, bin_a, gray_b, bin_b;
  logic       tick_a, wrap_a, tick_b, wrap_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Hand-computed Gray codes for binary 0..15.
  logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 clk = ~clk;

  gray_updown_counter #(.N(4), .DIVISOR(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_out(gray_a), .bin_out(bin_a), .tick(tick_a), .wrap(wrap_a)
  );

  gray_updown_counter #(.N(4), .DIVISOR(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_out(gray_b), .bin_out(bin_b), .tick(tick_b), .wrap(wrap_b)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bin_a, gray_a, tick_a, wrap_a} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got bin=%b gray=%b tick=%b wrap=%b, want all 0", bin_a, gray_a, tick_a, wrap_a);
    end
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    do_reset();
    up_dn = 1'b1;
    en = 1'b1;
    prev = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc(1);
        tests_run++;
        if (tick_a !== (c == 4)) begin
          tests_failed++;
          $display("FAIL up_tick step%0d cyc%0d: got %b want %b", k, c, tick_a, (c == 4));
        end
      end
      tests_run++;
      if (gray_a !== gray_tbl[k] || bin_a !== 4'(k) || $countones(gray_a ^ prev) != 1) begin
        tests_failed++;
        $display("FAIL up_seq step%0d: got gray=%b bin=%0d want gray=%b bin=%0d", k, gray_a, bin_a, gray_tbl[k], k);
      end
      prev = gray_a;
    end
  endtask

  task automatic test_wrap_up();
    cyc(32);
    tests_run++;
    if (bin_a !== 4'd15 || gray_a !== 4'b1000 || wrap_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL up_to_15: got bin=%0d gray=%b wrap=%b want 15 1000 0", bin_a, gray_a, wrap_a);
    end
    cyc(4);
    tests_run++;
    if (bin_a !== 4'd0 || gray_a !== 4'b0000 || wrap_a !== 1'b1 || tick_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_wrap: got bin=%0d gray=%b wrap=%b tick=%b want 0 0000 1 1", bin_a, gray_a, wrap_a, tick_a);
    end
    cyc(1);
    tests_run++;
    if (wrap_a !== 1'b0 || tick_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL up_wrap_pulse: got wrap=%b tick=%b want 0 0", wrap_a, tick_a);
    end
  endtask

  task automatic test_count_down();
    do_reset();
    up_dn = 1'b0;
    en = 1'b1;
    cyc(4);
    tests_run++;
    if (bin_a !== 4'd15 || gray_a !== 4'b1000 || wrap_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL down_wrap: got bin=%0d gray=%b wrap=%b want 15 1000 1", bin_a, gray_a, wrap_a);
    end
    cyc(4);
    tests_run++;
    if (bin_a !== 4'd14 || gray_a !== 4'b1001 || wrap_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_14: got bin=%0d gray=%b wrap=%b want 14 1001 0", bin_a, gray_a, wrap_a);
    end
    // Direction flip mid-stream: one Gray bit changes and count goes back up.
    up_dn = 1'b1;
    cyc(4);
    tests_run++;
    if (bin_a !== 4'd15 || gray_a !== 4'b1000 || wrap_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL dir_change: got bin=%0d gray=%b wrap=%b want 15 1000 0", bin_a, gray_a, wrap_a);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    up_dn = 1'b1;
    en = 1'b1;
    cyc(2);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      tests_run++;
      if (tick_a !== 1'b0 || bin_a !== 4'd0) begin
        tests_failed++;
        $display("FAIL hold cyc%0d: got tick=%b bin=%0d want 0 0", c, tick_a, bin_a);
      end
    end
    en = 1'b1;
    cyc(1);
    tests_run++;
    if (tick_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reenable_early: got tick=%b want 0", tick_a);
    end
    cyc(1);
    tests_run++;
    if (tick_a !== 1'b1 || bin_a !== 4'd1) begin
      tests_failed++;
      $display("FAIL reenable_tick: got tick=%b bin=%0d want 1 1", tick_a, bin_a);
    end
  endtask

  task automatic test_load();
    do_reset();
    up_dn = 1'b1;
    en = 1'b1;
    cyc(3);
    load = 1'b1;
    load_val = 4'd5;
    cyc(1);
    load = 1'b0;
    tests_run++;
    if (bin_a !== 4'd5 || gray_a !== 4'b0111 || tick_a !== 1'b0 || wrap_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL load: got bin=%0d gray=%b tick=%b wrap=%b want 5 0111 0 0", bin_a, gray_a, tick_a, wrap_a);
    end
    for (int c = 1; c <= 3; c++) begin
      cyc(1);
      tests_run++;
      if (tick_a !== 1'b0 || bin_a !== 4'd5) begin
        tests_failed++;
        $display("FAIL load_gap cyc%0d: got tick=%b bin=%0d want 0 5", c, tick_a, bin_a);
      end
    end
    cyc(1);
    tests_run++;
    if (tick_a !== 1'b1 || bin_a !== 4'd6 || gray_a !== 4'b0101) begin
      tests_failed++;
      $display("FAIL load_next: got tick=%b bin=%0d gray=%b want 1 6 0101", tick_a, bin_a, gray_a);
    end
  endtask

  task automatic test_async_reset_and_div1();
    do_reset();
    up_dn = 1'b1;
    en = 1'b1;
    cyc(4);
    tests_run++;
    if (tick_a !== 1'b1 || bin_a !== 4'd1) begin
      tests_failed++;
      $display("FAIL pre_reset: got tick=%b bin=%0d want 1 1", tick_a, bin_a);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bin_a, gray_a, tick_a, wrap_a} !== 10'd0 || {bin_b, gray_b, tick_b} !== 9'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got a=%b/%b/%b/%b b=%b/%b/%b want zeros",
               bin_a, gray_a, tick_a, wrap_a, bin_b, gray_b, tick_b);
    end
    cyc(1);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      tests_run++;
      if (gray_b !== gray_tbl[k] || tick_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL div1 step%0d: got gray=%b tick=%b want %b 1", k, gray_b, tick_b, gray_tbl[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_count_down();
    test_enable_hold();
    test_load();
    test_async_reset_and_div1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
